// File: rtl/action_scheduler_if.sv
// Eat/sleep scheduler bus: request/stat inputs from the system side and the
// action handshake toward homeActions, grouped for a single port connection.
interface action_scheduler_if #(
    parameter int unsigned STAT_W = 7
) ();
    logic              userEat;
    logic              userSleep;
    logic [STAT_W-1:0] hunger;
    logic [STAT_W-1:0] sleepiness;
    logic              actionDone;
    logic              doEat;
    logic              doSleep;
    logic              busy;
    logic [1:0]        activeAction;
    logic              timeoutErr;

    modport master (
        output userEat, userSleep, hunger, sleepiness, actionDone,
        input  doEat, doSleep, busy, activeAction, timeoutErr
    );

    modport slave (
        input  userEat, userSleep, hunger, sleepiness, actionDone,
        output doEat, doSleep, busy, activeAction, timeoutErr
    );
endinterface

// File: rtl/action_scheduler.sv
// Single owner of homeActions' doEat/doSleep: arbitrates user and autonomous
// requests round-robin, holds one action until done, then cools down; watchdog aborts.
module action_scheduler #(
    parameter int unsigned       STAT_W    = 7,
    parameter logic [STAT_W-1:0] HUNGER_TH = STAT_W'(80),
    parameter logic [STAT_W-1:0] SLEEP_TH  = STAT_W'(80),
    parameter int unsigned       COOLDOWN  = 50_000_000,
    parameter int unsigned       TIMEOUT   = 500_000_000
) (
    input  logic              clk,
    input  logic              resetn,
    action_scheduler_if.slave bus
);

    localparam int unsigned CNT_SRC = (TIMEOUT > COOLDOWN) ? TIMEOUT : COOLDOWN;
    localparam int unsigned CNT_W   = $clog2(CNT_SRC) + 1;

    localparam logic [1:0] ACT_NONE  = 2'b00;
    localparam logic [1:0] ACT_EAT   = 2'b01;
    localparam logic [1:0] ACT_SLEEP = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RELEASE,
        S_COOL
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [1:0]         act_q, act_d;
    logic               last_sleep_q, last_sleep_d;
    logic               eat_pend_q, eat_pend_d;
    logic               sleep_pend_q, sleep_pend_d;
    logic               eat_in_q, sleep_in_q;
    logic               tmo_err_q, tmo_err_d;
    logic               do_eat_q, do_eat_d;
    logic               do_sleep_q, do_sleep_d;
    logic               busy_q, busy_d;
    logic [1:0]         active_q, active_d;

    logic eat_rise, sleep_rise;
    logic eat_req, sleep_req;
    logic grant_eat;

    assign eat_rise   = bus.userEat & ~eat_in_q;
    assign sleep_rise = bus.userSleep & ~sleep_in_q;
    assign eat_req    = eat_pend_q | (bus.hunger >= HUNGER_TH);
    assign sleep_req  = sleep_pend_q | (bus.sleepiness >= SLEEP_TH);
    assign cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state, counter, request flags and registered-output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        act_d        = act_q;
        last_sleep_d = last_sleep_q;
        eat_pend_d   = eat_pend_q | eat_rise;
        sleep_pend_d = sleep_pend_q | sleep_rise;
        tmo_err_d    = tmo_err_q;
        grant_eat    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.actionDone && (eat_req || sleep_req)) begin
                    // Contention goes to whichever action was not served last
                    grant_eat = eat_req && (!sleep_req || last_sleep_q);
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    tmo_err_d = 1'b0;
                    if (grant_eat) begin
                        act_d        = ACT_EAT;
                        last_sleep_d = 1'b0;
                        eat_pend_d   = eat_rise;
                    end else begin
                        act_d        = ACT_SLEEP;
                        last_sleep_d = 1'b1;
                        sleep_pend_d = sleep_rise;
                    end
                end
            end
            S_RUN: begin
                if (bus.actionDone) begin
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = S_RELEASE;
                    tmo_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RELEASE: begin
                if (!bus.actionDone) begin
                    state_d = (COOLDOWN == 0) ? S_IDLE : S_COOL;
                    cnt_d   = '0;
                end
            end
            S_COOL: begin
                if (cnt_q >= CNT_W'(COOLDOWN - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase

        do_eat_d   = (state_d == S_RUN) && (act_d == ACT_EAT);
        do_sleep_d = (state_d == S_RUN) && (act_d == ACT_SLEEP);
        busy_d     = (state_d != S_IDLE);
        active_d   = ((state_d == S_RUN) || (state_d == S_RELEASE)) ? act_d : ACT_NONE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            act_q        <= ACT_NONE;
            last_sleep_q <= 1'b1;
            eat_pend_q   <= 1'b0;
            sleep_pend_q <= 1'b0;
            eat_in_q     <= 1'b0;
            sleep_in_q   <= 1'b0;
            tmo_err_q    <= 1'b0;
            do_eat_q     <= 1'b0;
            do_sleep_q   <= 1'b0;
            busy_q       <= 1'b0;
            active_q     <= ACT_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            act_q        <= act_d;
            last_sleep_q <= last_sleep_d;
            eat_pend_q   <= eat_pend_d;
            sleep_pend_q <= sleep_pend_d;
            eat_in_q     <= bus.userEat;
            sleep_in_q   <= bus.userSleep;
            tmo_err_q    <= tmo_err_d;
            do_eat_q     <= do_eat_d;
            do_sleep_q   <= do_sleep_d;
            busy_q       <= busy_d;
            active_q     <= active_d;
        end
    end

    assign bus.doEat        = do_eat_q;
    assign bus.doSleep      = do_sleep_q;
    assign bus.busy         = busy_q;
    assign bus.activeAction = active_q;
    assign bus.timeoutErr   = tmo_err_q;

endmodule

// File: tb/tb_action_scheduler.sv
// Bench for action_scheduler: homeActions stub, transaction-level schedule model
// feeding an expected-grant queue, and a monitor that checks every issued action.
module tb_action_scheduler;

    localparam int unsigned STAT_W   = 7;
    localparam int          COOLDOWN = 4;
    localparam int          TIMEOUT  = 20;
    localparam int          STUB_LAT = 5;
    localparam int          TH       = 80;
    localparam int          ACT_EAT  = 1;
    localparam int          ACT_SLEEP = 2;

    typedef struct {
        int act;
        int start;
        int dur;
        bit tmo;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ready_cyc = 10;
    bit   last_sleep = 1'b1;
    bit   stub_tmo = 1'b0;
    logic done_at_edge = 1'b0;
    exp_t exp_q[$];

    action_scheduler_if #(.STAT_W(STAT_W)) bus ();

    action_scheduler #(
        .STAT_W   (STAT_W),
        .HUNGER_TH(7'd80),
        .SLEEP_TH (7'd80),
        .COOLDOWN (COOLDOWN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) done_at_edge <= bus.actionDone;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, want, cyc);
        end
    endtask

    // homeActions stub: done 5 cycles after do* rises, dropped 1 cycle after do* falls
    int stub_hi = 0;
    int stub_lo = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            stub_hi = 0;
            stub_lo = 0;
            bus.actionDone = 1'b0;
        end else if (bus.doEat || bus.doSleep) begin
            stub_hi++;
            stub_lo = 0;
            if (!stub_tmo && stub_hi >= STUB_LAT + 1) bus.actionDone = 1'b1;
        end else begin
            stub_hi = 0;
            stub_lo++;
            if (stub_lo >= 2) bus.actionDone = 1'b0;
        end
    end

    // Monitor: pops the expected grant on each do* rise, checks length/error on fall
    exp_t cur;
    bit   mon_on = 1'b0;
    bit   prev_e = 1'b0;
    bit   prev_s = 1'b0;
    int   run_len = 0;
    int   cool_chk = -1;
    always @(negedge clk) begin
        if (!resetn) begin
            mon_on   = 1'b0;
            prev_e   = 1'b0;
            prev_s   = 1'b0;
            cool_chk = -1;
            exp_q.delete();
        end else begin
            check("do_onehot", int'(bus.doEat & bus.doSleep), 0);
            if ((bus.doEat && !prev_e) || (bus.doSleep && !prev_s)) begin
                check("grant_while_done", int'(done_at_edge), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("grant_action", bus.doEat ? ACT_EAT : ACT_SLEEP, cur.act);
                    check("grant_cycle", cyc, cur.start);
                    check("grant_activeAction", int'(bus.activeAction), cur.act);
                    check("grant_busy", int'(bus.busy), 1);
                    check("grant_timeoutErr", int'(bus.timeoutErr), 0);
                    mon_on  = 1'b1;
                    run_len = 0;
                end
            end
            if (mon_on && (bus.doEat || bus.doSleep)) run_len++;
            if (mon_on && !bus.doEat && !bus.doSleep && (prev_e || prev_s)) begin
                check("run_length", run_len, cur.dur);
                check("release_timeoutErr", int'(bus.timeoutErr), int'(cur.tmo));
                check("release_activeAction", int'(bus.activeAction), cur.act);
                check("release_busy", int'(bus.busy), 1);
                cool_chk = cyc + (cur.tmo ? 1 : 2);
                mon_on   = 1'b0;
            end
            if (cyc == cool_chk) begin
                check("cool_activeAction", int'(bus.activeAction), 0);
                check("cool_busy", int'(bus.busy), 1);
            end
            prev_e = bus.doEat;
            prev_s = bus.doSleep;
        end
    end

    task automatic go_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // One burst of requests issued while idle; the schedule model predicts every grant
    task automatic burst(input bit ue, input bit us, input int hv, input int sv,
                         input int me, input int ms, input bit tmo, input bit rst_mid);
        int   n, g, last_g, d, idle_at, act;
        bit   pe, ps, ae, as_, er, sr, first, any;
        exp_t e;
        go_cycle(ready_cyc);
        stub_tmo = tmo;
        n  = cyc;
        d  = tmo ? TIMEOUT : STUB_LAT + 1;
        pe = ue;
        ps = us;
        ae = (hv >= TH);
        as_ = (sv >= TH);
        any = pe | ps | ae | as_;
        g = n + 2;
        last_g = g;
        first = 1'b1;
        while (pe || ps || (first && (ae || as_))) begin
            er = pe || (first && ae);
            sr = ps || (first && as_);
            if (er && sr) act = last_sleep ? ACT_EAT : ACT_SLEEP;
            else          act = er ? ACT_EAT : ACT_SLEEP;
            if (act == ACT_EAT) pe = 1'b0;
            else                ps = 1'b0;
            last_sleep = (act == ACT_SLEEP);
            e.act = act; e.start = g; e.dur = d; e.tmo = tmo;
            exp_q.push_back(e);
            if (first) begin
                if (me > 0) pe = 1'b1;
                if (ms > 0) ps = 1'b1;
                first = 1'b0;
            end
            last_g = g;
            g = g + d + (tmo ? 1 : 2) + COOLDOWN + 1;
        end
        idle_at = any ? last_g + d + (tmo ? 1 : 2) + COOLDOWN : n + 12;

        bus.userEat = ue;
        bus.userSleep = us;
        @(negedge clk);
        bus.userEat = 1'b0;
        bus.userSleep = 1'b0;
        bus.hunger = STAT_W'(hv);
        bus.sleepiness = STAT_W'(sv);
        @(negedge clk);
        bus.hunger = STAT_W'($urandom_range(0, TH - 1));
        bus.sleepiness = STAT_W'($urandom_range(0, TH - 1));

        if (rst_mid) begin
            go_cycle(n + 5);
            check("pre_reset_do", int'(bus.doEat | bus.doSleep), 1);
            resetn = 1'b0;
            #1;
            check("async_reset_doEat", int'(bus.doEat), 0);
            check("async_reset_busy", int'(bus.busy), 0);
            check("async_reset_activeAction", int'(bus.activeAction), 0);
            last_sleep = 1'b1;
            stub_tmo = 1'b0;
            @(negedge clk);
            @(negedge clk);
            resetn = 1'b1;
            ready_cyc = cyc + 1;
            return;
        end

        go_cycle(n + 4);
        bus.userEat = (me > 0);
        bus.userSleep = (ms > 0);
        @(negedge clk);
        bus.userEat = 1'b0;
        bus.userSleep = 1'b0;
        @(negedge clk);
        bus.userEat = (me > 1);
        bus.userSleep = (ms > 1);
        @(negedge clk);
        bus.userEat = 1'b0;
        bus.userSleep = 1'b0;

        go_cycle(idle_at);
        check("idle_busy", int'(bus.busy), 0);
        check("idle_activeAction", int'(bus.activeAction), 0);
        check("idle_do", int'(bus.doEat | bus.doSleep), 0);
        check("idle_queue_drained", exp_q.size(), 0);
        ready_cyc = idle_at;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_watchdog: got cycle %0d expected completion", cyc);
        $fatal(1, "simulation did not complete");
    end

    initial begin
        bit ue, us;
        int hv, sv;
        resetn = 1'b0;
        bus.userEat = 1'b0;
        bus.userSleep = 1'b0;
        bus.hunger = '0;
        bus.sleepiness = '0;
        @(negedge clk);
        check("reset_doEat", int'(bus.doEat), 0);
        check("reset_doSleep", int'(bus.doSleep), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_activeAction", int'(bus.activeAction), 0);
        check("reset_timeoutErr", int'(bus.timeoutErr), 0);
        @(negedge clk);
        resetn = 1'b1;

        burst(1, 0, 0, 0, 0, 0, 0, 0);      // eat at cycle 10, doEat 12..17
        burst(0, 1, 0, 0, 0, 0, 0, 0);      // sleep only
        burst(1, 1, 0, 0, 0, 0, 0, 0);      // contention after sleep: eat then sleep
        burst(0, 0, 80, 79, 0, 0, 0, 0);    // auto eat at threshold
        burst(0, 0, 79, 79, 0, 0, 0, 0);    // just below threshold: nothing
        burst(1, 0, 0, 0, 0, 0, 1, 0);      // watchdog abort
        burst(0, 1, 0, 0, 0, 0, 0, 0);      // next grant clears timeoutErr
        burst(1, 0, 0, 0, 0, 1, 0, 0);      // sleep edge during eat run
        burst(0, 1, 0, 0, 2, 2, 0, 0);      // merged repeat edges during run

        for (int i = 0; i < 30; i++) begin
            ue = 1'($urandom_range(0, 1));
            us = 1'($urandom_range(0, 1));
            hv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TH, 127)) : int'($urandom_range(0, TH - 1));
            sv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TH, 127)) : int'($urandom_range(0, TH - 1));
            if (!ue && !us && hv < TH && sv < TH) ue = 1'b1;
            burst(ue, us, hv, sv, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  ($urandom_range(0, 4) == 0), 0);
        end

        burst(1, 0, 0, 0, 0, 0, 0, 1);      // reset mid-run
        burst(1, 1, 0, 0, 0, 0, 0, 0);      // lastServed back to sleep: eat first

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
